// File: rtl/flag_z_update_sequencer.sv
// flag_z_update_sequencer: sequences Z flag register writes for ALU updates, EX AF,AF' and POP AF
module flag_z_update_sequencer #(
  parameter int NUM_SRC = 12,
  parameter int POP_TIMEOUT = 15,
  parameter int CNT_W = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_cmd,
  input  logic [3:0]         req_zsrc,
  input  logic               pop_data_valid,
  output logic               PF_Write_Z,
  output logic [NUM_SRC-1:0] notPF_Select_Z,
  output logic               PR_Ex,
  output logic               notPR_Ex,
  output logic               PR_Write,
  output logic               notPR_Write,
  output logic               shadow_we,
  output logic               busy,
  output logic               done,
  output logic               err
);
  typedef enum logic [2:0] {IDLE, UPDATE, EXCH, POP_WAIT, POP_WR} state_t;
  state_t state, state_n;
  logic [3:0] zsrc_q, zsrc_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic done_n, err_n, pf_n, ex_n, wr_n;
  logic [NUM_SRC-1:0] sel_n;
  // next state, captured command and the registered output values that go with the next state
  always_comb begin
    state_n = state;
    zsrc_n = zsrc_q;
    cnt_n = cnt;
    done_n = 1'b0;
    err_n = 1'b0;
    case (state)
      IDLE:
        if (req_valid)
          case (req_cmd)
            2'd0: begin
              zsrc_n = req_zsrc;
              state_n = int'(req_zsrc) < NUM_SRC ? UPDATE : IDLE;
              err_n = int'(req_zsrc) >= NUM_SRC;
            end
            2'd1: state_n = EXCH;
            2'd2: begin
              state_n = POP_WAIT;
              cnt_n = '0;
            end
            default: done_n = 1'b1;
          endcase
      POP_WAIT:
        if (pop_data_valid) state_n = POP_WR;
        else if (cnt == CNT_W'(POP_TIMEOUT - 1)) begin
          state_n = IDLE;
          err_n = 1'b1;
        end else cnt_n = cnt + 1'b1;
      default: begin
        state_n = IDLE;
        done_n = 1'b1;
      end
    endcase
    pf_n = state_n == UPDATE;
    ex_n = state_n == EXCH;
    wr_n = state_n == POP_WR;
    sel_n = pf_n ? ~({{(NUM_SRC-1){1'b0}}, 1'b1} << zsrc_n) : '1;
  end
  // state and every output registered so the Z register sees glitch-free one-cycle controls
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      zsrc_q <= '0;
      cnt <= '0;
      req_ready <= 1'b1;
      busy <= 1'b0;
      PF_Write_Z <= 1'b0;
      notPF_Select_Z <= '1;
      PR_Ex <= 1'b0;
      notPR_Ex <= 1'b1;
      PR_Write <= 1'b0;
      notPR_Write <= 1'b1;
      shadow_we <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      zsrc_q <= zsrc_n;
      cnt <= cnt_n;
      req_ready <= state_n == IDLE;
      busy <= state_n != IDLE;
      PF_Write_Z <= pf_n;
      notPF_Select_Z <= sel_n;
      PR_Ex <= ex_n;
      notPR_Ex <= ~ex_n;
      PR_Write <= wr_n;
      notPR_Write <= ~wr_n;
      shadow_we <= ex_n;
      done <= done_n;
      err <= err_n;
    end
  end
endmodule

// File: doc/flag_z_update_sequencer.md
Name: flag_z_update_sequencer

Overview:
Sequences all writes to the Z flag register: normal ALU flag updates with a selected Z source, EX AF,AF' shadow exchange, and POP AF restore.
- Accepts one command at a time from the microcode sequencer over a valid/ready handshake.
- Drives the Z register's PF_Write_Z, active-low one-hot source selects, and PR_Ex/PR_Write mux controls.
- All outputs are registered, so the register sees glitch-free controls for exactly one Clk cycle.

Parameters:
NUM_SRC, 12, number of Z sources; select index order is is8bitEqual, CY4, isResultLow0, isResult0, ALU0..ALU7.
POP_TIMEOUT, 15, maximum cycles POP_WAIT waits for pop_data_valid; must be 1..255.
CNT_W, 8, width of the timeout counter.

Ports:
Clk  in  1  system clock; all state updates on the rising edge.
Reset  in  1  synchronous, active-high reset.
req_valid  in  1  command valid.
req_ready  out  1  high only in IDLE.
req_cmd  in  2  0=ALU_UPDATE, 1=EX_AF, 2=POP_AF, 3=HOLD (no-op).
req_zsrc  in  4  Z source index for ALU_UPDATE, 0..NUM_SRC-1.
pop_data_valid  in  1  stack byte is present on the ALU result bus.
PF_Write_Z  out  1  high = replace Z; low = Z holds.
notPF_Select_Z  out  NUM_SRC  active-low one-hot source select; bit i maps to source index i.
PR_Ex  out  1  selects the shadow Z as the next value.
notPR_Ex  out  1  always ~PR_Ex.
PR_Write  out  1  selects the stack byte (bit 6) as the next value.
notPR_Write  out  1  always ~PR_Write.
shadow_we  out  1  shadow Z captures the current Z (second half of exchange).
busy  out  1  state != IDLE.
done  out  1  one-cycle pulse when a command completes.
err  out  1  one-cycle pulse on bad zsrc or POP timeout.

Behaviour:
- States: IDLE, UPDATE, EXCH, POP_WAIT, POP_WR.
- Reset values (Reset=1 at an edge takes effect at that edge, from any state):
  - state=IDLE, req_ready=1.
  - notPF_Select_Z all ones, PF_Write_Z=0.
  - PR_Ex=0, notPR_Ex=1, PR_Write=0, notPR_Write=1.
  - shadow_we=0, busy=0, done=0, err=0, counter=0.
- Reset mid-command aborts with no further strobes; no partial exchange is completed.
- Handshake: a command is accepted on an edge with req_valid & req_ready. Inputs are captured at acceptance; later changes are ignored.
- ALU_UPDATE, valid zsrc:
  - Cycle after accept is UPDATE: PF_Write_Z=1 and notPF_Select_Z[zsrc]=0, all other select bits 1.
  - Next edge: back to IDLE, done=1 for one cycle.
  - Latency is 1 cycle from accept to strobe; the Z register captures at the end of UPDATE.
- ALU_UPDATE, zsrc >= NUM_SRC: no strobes, no state change beyond IDLE; err=1 the cycle after accept; done stays 0.
- EX_AF:
  - EXCH lasts one cycle: PR_Ex=1 and shadow_we=1 together, so the register loads the shadow Z while the shadow loads the old Z.
  - PF_Write_Z=0 and all selects inactive during EXCH.
  - Then IDLE with done=1.
- POP_AF:
  - Enter POP_WAIT with counter cleared; counter increments each POP_WAIT cycle.
  - pop_data_valid=1 in POP_WAIT: go to POP_WR on the next edge.
  - POP_WR lasts one cycle: PR_Write=1 and PF_Write_Z=0. Then IDLE with done=1.
  - If the counter reaches POP_TIMEOUT without valid: go to IDLE, err=1, no PR_Write pulse.
  - pop_data_valid in the same cycle the counter reaches POP_TIMEOUT: valid wins.
- HOLD: accepted, no strobes; done=1 the next cycle.
- Invariants:
  - At most one of {PF_Write_Z, PR_Ex, PR_Write} is high in any cycle.
  - notPF_Select_Z has at most one zero, and only while PF_Write_Z=1.
  - Each complementary pair is exactly complementary every cycle, including reset.
- Back-to-back commands: req_ready rises in the cycle done pulses. A new command may be accepted on that same edge, giving a one-cycle IDLE gap between strobes.
- pop_data_valid is ignored outside POP_WAIT.

Test Plan:
- Reset held for 3 cycles -> notPF_Select_Z=12'hFFF, PF_Write_Z=0, notPR_Ex=1, notPR_Write=1, req_ready=1, busy=0.
- ALU_UPDATE with zsrc=3 (isResult0) -> one cycle later PF_Write_Z=1 and notPF_Select_Z=12'hFF7 for exactly 1 cycle, then done=1; sweep zsrc 0..11 with the expected one-hot zero in each case.
- ALU_UPDATE with zsrc=12 -> err pulses once, no select bit low, PF_Write_Z stays 0, done=0.
- EX_AF -> PR_Ex=1, notPR_Ex=0 and shadow_we=1 for one cycle, then done; issue twice back-to-back -> two pulses separated by exactly one IDLE cycle.
- POP_AF with pop_data_valid after 4 cycles -> PR_Write=1 one cycle after valid, then done. POP_AF with no valid -> after 15 POP_WAIT cycles err=1, PR_Write never high.
- Reset asserted during POP_WAIT, and separately during EXCH -> at the next edge all strobes are inactive, state=IDLE, and no done or err pulse.
